// File: rtl/quick_spi_pkg.sv
// Shared encodings for the quick_spi master/slave pair.
package quick_spi_pkg;

  typedef enum logic {
    SLV_IDLE   = 1'b0,
    SLV_ACTIVE = 1'b1
  } slv_state_e;

  // {CPOL, CPHA}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

endpackage

// File: rtl/quick_spi_slave_sync.sv
// Two-flop synchroniser for an asynchronous pin, with single-cycle edge pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [1:0] ff;
  logic       prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff   <= {2{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      ff   <= {ff[0], din};
      prev <= ff[1];
    end
  end

  assign sync = ff[1];
  assign rise = ff[1] & ~prev;
  assign fall = ~ff[1] & prev;

endmodule

// File: rtl/quick_spi_slave.sv
// SPI responder: oversamples sclk/ss_n/mosi in the clk domain, full-duplex word transfer
// with a one-entry tx holding register.
module quick_spi_slave
  import quick_spi_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter bit                    CPOL       = 1'b0,
  parameter bit                    CPHA       = 1'b0,
  parameter bit                    MSB_FIRST  = 1'b0,
  parameter logic [DATA_WIDTH-1:0] TX_FILL    = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun,
  output logic                  frame_abort
);

  localparam int CW = $clog2(DATA_WIDTH);

  slv_state_e            state_q, state_d;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] rx_sr, tx_sr, hold, rx_next, next_word;
  logic                  hold_full, miso_q;
  logic [1:0]            mosi_ff;
  logic                  mosi_s;
  logic                  sclk_s, sclk_rise, sclk_fall, ss_s, ss_rise, ss_fall;
  logic                  active, lead, trail, sample_e, shift_e, last, load, tx_fire, underrun;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
    .clk(clk), .reset_n(reset_n), .din(sclk),
    .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .reset_n(reset_n), .din(ss_n),
    .sync(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mosi_ff <= 2'b00;
    else          mosi_ff <= {mosi_ff[0], mosi};
  end
  assign mosi_s = mosi_ff[1];

  // Edges are gated by the synced select so an ss_n release wins over a coincident edge.
  assign active   = (state_q == SLV_ACTIVE);
  assign lead     = (sclk_rise | sclk_fall) & (sclk_s != CPOL);
  assign trail    = (sclk_rise | sclk_fall) & (sclk_s == CPOL);
  assign sample_e = active & ~ss_s & (CPHA ? trail : lead);
  assign shift_e  = active & ~ss_s & (CPHA ? lead : trail);
  assign last     = sample_e && (bit_cnt == CW'(DATA_WIDTH-1));
  assign load     = (~active & ss_fall) | last;

  assign tx_ready  = ~hold_full;
  assign tx_fire   = tx_valid & tx_ready;
  assign underrun  = load & ~hold_full & ~tx_fire;
  assign next_word = hold_full ? hold : (tx_fire ? tx_data : TX_FILL);
  assign rx_next   = MSB_FIRST ? {rx_sr[DATA_WIDTH-2:0], mosi_s}
                               : {mosi_s, rx_sr[DATA_WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLV_IDLE:   if (ss_fall) state_d = SLV_ACTIVE;
      SLV_ACTIVE: if (ss_rise) state_d = SLV_IDLE;
      default:    state_d = SLV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SLV_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      miso_q      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      // A write landing on an empty-holding boundary bypasses straight to the shifter.
      if (tx_fire && !load) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (!active) begin
        bit_cnt <= '0;
        if (ss_fall) begin
          tx_underrun <= underrun;
          if (CPHA) begin
            tx_sr <= next_word;
          end else begin
            miso_q <= first_bit(next_word);
            tx_sr  <= advance(next_word);
          end
        end
      end else if (ss_rise) begin
        bit_cnt     <= '0;
        frame_abort <= (bit_cnt != '0);
      end else begin
        if (sample_e) begin
          rx_sr <= rx_next;
          if (last) begin
            bit_cnt     <= '0;
            rx_data     <= rx_next;
            rx_valid    <= 1'b1;
            tx_sr       <= next_word;
            tx_underrun <= underrun;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        if (shift_e) begin
          miso_q <= first_bit(tx_sr);
          tx_sr  <= advance(tx_sr);
        end
      end
    end
  end

  assign busy = active;
  assign miso = active ? miso_q : 1'bz;

endmodule
